// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage WISC core: load-use stalls, memory freezes,
// redirect flushes and HALT latching, plus saturating stall/flush performance counters.
module hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       rs_d,
    input  logic [2:0]       rt_d,
    input  logic             valid_rs_d,
    input  logic             valid_rt_d,
    input  logic [2:0]       rd_e,
    input  logic             mem_read_e,
    input  logic             reg_write_e,
    input  logic             branch_taken_e,
    input  logic             imem_stall,
    input  logic             dmem_req,
    input  logic             dmem_done,
    input  logic             halt_m,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_write_en,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       dbg_state,
    output logic             dbg_redirect_pending
);

    // Data-memory handshake: dmem_req is the valid of the MEM-stage access and dmem_done is
    // its ready; the access completes in the cycle both are high, and until then the
    // pipeline from PC through EX/MEM holds while MEM/WB receives bubbles.

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t state, state_next;
    logic   redirect_pending, redirect_pending_next;
    logic   hazard_eval;
    logic   redirect_fire;
    logic   load_use;
    logic   mem_busy;

    // R0 is an ordinary register in this ISA, so no zero-register exclusion.
    assign load_use = mem_read_e & reg_write_e &
                      ((valid_rs_d & (rs_d == rd_e)) | (valid_rt_d & (rt_d == rd_e)));
    assign mem_busy = dmem_req & ~dmem_done;

    assign dbg_state            = state;
    assign dbg_redirect_pending = redirect_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            redirect_pending <= 1'b0;
        end else begin
            state            <= state_next;
            redirect_pending <= redirect_pending_next;
        end
    end

    always_comb begin
        pc_write_en           = 1'b1;
        ifid_write_en         = 1'b1;
        ifid_flush            = 1'b0;
        idex_bubble           = 1'b0;
        exmem_write_en        = 1'b1;
        memwb_bubble          = 1'b0;
        halted                = 1'b0;
        state_next            = state;
        redirect_pending_next = redirect_pending;
        hazard_eval           = 1'b0;
        redirect_fire         = 1'b0;

        if (rst) begin
            pc_write_en    = 1'b0;
            ifid_write_en  = 1'b0;
            exmem_write_en = 1'b0;
            ifid_flush     = 1'b1;
            idex_bubble    = 1'b1;
            memwb_bubble   = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        pc_write_en    = 1'b0;
                        ifid_write_en  = 1'b0;
                        exmem_write_en = 1'b0;
                        memwb_bubble   = 1'b1;
                        state_next     = MEM_WAIT;
                    end else if (halt_m) begin
                        // HALT itself moves on into MEM/WB; everything upstream stops.
                        pc_write_en    = 1'b0;
                        ifid_write_en  = 1'b0;
                        exmem_write_en = 1'b0;
                        state_next     = HALT;
                    end else begin
                        hazard_eval = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_done) begin
                        pc_write_en    = 1'b0;
                        ifid_write_en  = 1'b0;
                        exmem_write_en = 1'b0;
                        memwb_bubble   = 1'b1;
                    end else begin
                        hazard_eval = 1'b1;
                        state_next  = RUN;
                    end
                end
                HALT: begin
                    pc_write_en    = 1'b0;
                    ifid_write_en  = 1'b0;
                    exmem_write_en = 1'b0;
                    ifid_flush     = 1'b1;
                    idex_bubble    = 1'b1;
                    memwb_bubble   = 1'b1;
                    halted         = 1'b1;
                end
                default: begin
                    state_next = RUN;
                end
            endcase

            if (hazard_eval) begin
                // A pending redirect means the fetch under the stall is wrong-path.
                if (redirect_pending && !imem_stall) begin
                    ifid_flush            = 1'b1;
                    redirect_pending_next = 1'b0;
                end
                if (branch_taken_e) begin
                    ifid_flush    = 1'b1;
                    idex_bubble   = 1'b1;
                    redirect_fire = 1'b1;
                    if (imem_stall) begin
                        redirect_pending_next = 1'b1;
                    end
                end else if (load_use) begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_bubble   = 1'b1;
                end else if (imem_stall) begin
                    pc_write_en = 1'b0;
                    ifid_flush  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write_en && !halted && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (redirect_fire && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

    halted_freezes_all: assert property (@(posedge clk) disable iff (rst)
        halted |-> (!pc_write_en && !ifid_write_en && !exmem_write_en));

    halt_state_sticky: assert property (@(posedge clk) disable iff (rst)
        (state == HALT) |=> (state == HALT));

endmodule
